// File: rtl/pipe_ctrl_unit.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Generates per-stage stall/flush strobes for load-use bubbles, branch/jump
// redirects, data-memory wait freezes and a debug halt/single-step FSM.
// Also keeps saturating stall/flush counters and a sticky dmem-timeout flag.
module pipe_ctrl_unit #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             id_valid_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_valid_i,
    input  logic             bj_sig_i,
    input  logic             dmem_busy_i,
    input  logic             halt_req_i,
    input  logic             step_req_i,
    input  logic             resume_req_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_timeout_o
);

    // Busy counter only needs to reach BUSY_TIMEOUT, where it saturates.
    localparam int unsigned BC_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_STEP
    } state_e;

    state_e            state_q;
    logic              halted_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [BC_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic              err_q, err_d;

    logic              frz;
    logic              redirect;
    logic              rs_match;
    logic              load_use;

    // Hazard detection: freeze dominates, then redirect, then load-use.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        frz      = 1'b0;
        redirect = 1'b0;
        rs_match = 1'b0;
        load_use = 1'b0;

        frz      = dmem_busy_i | (state_q == ST_HALTED);
        redirect = ~frz & bj_sig_i & ex_valid_i;
        rs_match = (id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                   (id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i));
        // The ID instruction is on the wrong path during a redirect, so a
        // load-use match there must not bubble it.
        load_use = ~frz & ~redirect & ex_valid_i & ex_memread_i & id_valid_i &
                   (ex_rd_addr_i != 5'd0) & rs_match;
    end

    // Stage strobes derived from the hazard classification.
    always_comb begin
        stall_if_o  = frz | load_use;
        stall_id_o  = frz;
        stall_ex_o  = frz;
        stall_mem_o = frz;
        flush_if_o  = redirect;
        flush_id_o  = redirect | load_use;
        // Re-halt after a single step kills the stepped EX instruction.
        flush_ex_o  = (state_q == ST_STEP) & ~dmem_busy_i & halt_req_i;
    end

    // Debug FSM: RUN -> HALTED on halt, HALTED -> RUN/STEP, STEP -> HALTED once free.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req_i) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (resume_req_i) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end else if (step_req_i) begin
                        state_q  <= ST_STEP;
                        halted_q <= 1'b0;
                    end
                end
                ST_STEP: begin
                    // A busy memory holds the step until one free advance occurs.
                    if (!dmem_busy_i) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Next-state for saturating performance counters and the busy watchdog.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        busy_cnt_d  = busy_cnt_q;

        if ((state_q == ST_RUN) && stall_if_o && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        if (redirect && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);

        if (!dmem_busy_i)
            busy_cnt_d = '0;
        else if (busy_cnt_q != BC_W'(BUSY_TIMEOUT))
            busy_cnt_d = busy_cnt_q + BC_W'(1);

        // Flag sets on the same edge the counter reaches the limit.
        err_d = err_q | (busy_cnt_d == BC_W'(BUSY_TIMEOUT));
    end

    // Counter and error-flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            busy_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
            err_q       <= err_d;
        end
    end

    assign halted_o      = halted_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: a table of single-cycle strobe
// vectors followed by hand-written multi-cycle sequences.
module tb_pipe_ctrl_unit;

    localparam int unsigned CNT_W        = 2;
    localparam int unsigned BUSY_TIMEOUT = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic             id_uses_rs1_i, id_uses_rs2_i, id_valid_i;
    logic             ex_memread_i, ex_valid_i, bj_sig_i, dmem_busy_i;
    logic             halt_req_i, step_req_i, resume_req_i;
    logic             stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic             flush_if_o, flush_id_o, flush_ex_o;
    logic             halted_o, err_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    pipe_ctrl_unit #(.CNT_W(CNT_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .id_valid_i    (id_valid_i),
        .ex_memread_i  (ex_memread_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_valid_i    (ex_valid_i),
        .bj_sig_i      (bj_sig_i),
        .dmem_busy_i   (dmem_busy_i),
        .halt_req_i    (halt_req_i),
        .step_req_i    (step_req_i),
        .resume_req_i  (resume_req_i),
        .stall_if_o    (stall_if_o),
        .stall_id_o    (stall_id_o),
        .stall_ex_o    (stall_ex_o),
        .stall_mem_o   (stall_mem_o),
        .flush_if_o    (flush_if_o),
        .flush_id_o    (flush_id_o),
        .flush_ex_o    (flush_ex_o),
        .halted_o      (halted_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
        .err_timeout_o (err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Strobe bundle order: {stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id, flush_ex}
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       idv;
        logic       mr;
        logic [4:0] rd;
        logic       exv;
        logic       bj;
        logic       busy;
        logic [6:0] exp_strb;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    function automatic logic [6:0] strobes();
        return {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
                flush_if_o, flush_id_o, flush_ex_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_rd_addr_i = '0;
        id_uses_rs1_i = 0;  id_uses_rs2_i = 0;  id_valid_i   = 0;
        ex_memread_i  = 0;  ex_valid_i    = 0;  bj_sig_i     = 0;
        dmem_busy_i   = 0;  halt_req_i    = 0;  step_req_i   = 0;
        resume_req_i  = 0;
    endtask

    // rd=5 load in EX, ID reads x5 through rs2.
    task automatic drive_load_use();
        ex_memread_i = 1; ex_rd_addr_i = 5'd5; ex_valid_i = 1;
        id_rs2_addr_i = 5'd5; id_uses_rs2_i = 1; id_valid_i = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1;
        clear_inputs();
        next_cycle();
        rst_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rs1    rs2    u1 u2 idv mr rd     exv bj busy  strobes
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 0,  0, 5'd0, 0,  0, 0, 7'b0000000}; // idle
        vecs[1]  = '{5'd5, 5'd0, 1, 0, 1,  1, 5'd5, 1,  0, 0, 7'b1000010}; // rs1 load-use
        vecs[2]  = '{5'd0, 5'd5, 0, 1, 1,  1, 5'd5, 1,  0, 0, 7'b1000010}; // rs2 load-use
        vecs[3]  = '{5'd0, 5'd0, 1, 1, 1,  1, 5'd0, 1,  0, 0, 7'b0000000}; // rd = x0
        vecs[4]  = '{5'd5, 5'd0, 0, 0, 1,  1, 5'd5, 1,  0, 0, 7'b0000000}; // rs1 not used
        vecs[5]  = '{5'd5, 5'd0, 1, 0, 1,  1, 5'd5, 0,  0, 0, 7'b0000000}; // EX invalid
        vecs[6]  = '{5'd5, 5'd0, 1, 0, 1,  0, 5'd5, 1,  0, 0, 7'b0000000}; // not a load
        vecs[7]  = '{5'd5, 5'd0, 1, 0, 0,  1, 5'd5, 1,  0, 0, 7'b0000000}; // ID invalid
        vecs[8]  = '{5'd6, 5'd0, 1, 0, 1,  1, 5'd5, 1,  0, 0, 7'b0000000}; // reg mismatch
        vecs[9]  = '{5'd0, 5'd0, 0, 0, 0,  0, 5'd0, 1,  1, 0, 7'b0000110}; // redirect
        vecs[10] = '{5'd0, 5'd0, 0, 0, 0,  0, 5'd0, 0,  1, 0, 7'b0000000}; // bj, EX invalid
        vecs[11] = '{5'd5, 5'd0, 1, 0, 1,  1, 5'd5, 1,  1, 0, 7'b0000110}; // redirect beats load-use
        vecs[12] = '{5'd0, 5'd0, 0, 0, 0,  0, 5'd0, 0,  0, 1, 7'b1111000}; // dmem freeze
        vecs[13] = '{5'd5, 5'd0, 1, 0, 1,  1, 5'd5, 1,  1, 1, 7'b1111000}; // freeze beats all
        vecs[14] = '{5'd7, 5'd9, 1, 1, 1,  1, 5'd9, 1,  0, 0, 7'b1000010}; // rs2 hits, rs1 misses

        clk_i = 0;
        do_reset();
        sample();
        check("reset_strobes", 32'(strobes()), 32'd0);
        check("reset_halted", 32'(halted_o), 32'd0);
        check("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check("reset_flush_cnt", 32'(flush_cnt_o), 32'd0);
        check("reset_err", 32'(err_timeout_o), 32'd0);

        // Table of single-cycle strobe vectors, all in RUN.
        next_cycle();
        for (int i = 0; i < NVEC; i++) begin
            id_rs1_addr_i = vecs[i].rs1;  id_rs2_addr_i = vecs[i].rs2;
            id_uses_rs1_i = vecs[i].u1;   id_uses_rs2_i = vecs[i].u2;
            id_valid_i    = vecs[i].idv;  ex_memread_i  = vecs[i].mr;
            ex_rd_addr_i  = vecs[i].rd;   ex_valid_i    = vecs[i].exv;
            bj_sig_i      = vecs[i].bj;   dmem_busy_i   = vecs[i].busy;
            sample();
            check($sformatf("vec%0d_strobes", i), 32'(strobes()), 32'(vecs[i].exp_strb));
            next_cycle();
        end

        // Load-use bubble lasts one cycle once the load moves on.
        do_reset();
        drive_load_use();
        sample();
        check("lu_c0_strobes", 32'(strobes()), 32'b1000010);
        next_cycle();
        ex_valid_i = 0; ex_memread_i = 0;
        sample();
        check("lu_c1_strobes", 32'(strobes()), 32'd0);
        check("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);

        // Redirect beats load-use and is counted.
        do_reset();
        drive_load_use();
        bj_sig_i = 1;
        sample();
        check("rd_strobes", 32'(strobes()), 32'b0000110);
        next_cycle();
        clear_inputs();
        sample();
        check("rd_flush_cnt", 32'(flush_cnt_o), 32'd1);
        check("rd_stall_cnt", 32'(stall_cnt_o), 32'd0);

        // dmem freeze holds a pending branch, which redirects afterwards.
        do_reset();
        dmem_busy_i = 1; bj_sig_i = 1; ex_valid_i = 1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("frz_c%0d_strobes", c), 32'(strobes()), 32'b1111000);
            next_cycle();
        end
        dmem_busy_i = 0;
        sample();
        check("frz_c3_strobes", 32'(strobes()), 32'b0000110);
        next_cycle();
        clear_inputs();
        sample();
        check("frz_stall_cnt", 32'(stall_cnt_o), 32'd3);
        check("frz_flush_cnt", 32'(flush_cnt_o), 32'd1);
        check("frz_err", 32'(err_timeout_o), 32'd0);

        // Halt, busy single step, re-halt with EX flush, resume.
        do_reset();
        halt_req_i = 1;
        sample();
        check("halt_req_strobes", 32'(strobes()), 32'd0);
        check("halt_req_halted", 32'(halted_o), 32'd0);
        next_cycle();
        halt_req_i = 0;
        sample();
        check("halted_flag", 32'(halted_o), 32'd1);
        check("halted_strobes", 32'(strobes()), 32'b1111000);
        next_cycle();
        sample();
        check("halted_stays", 32'(halted_o), 32'd1);
        step_req_i = 1; dmem_busy_i = 1;
        next_cycle();
        step_req_i = 0;
        sample();
        check("step_busy1_halted", 32'(halted_o), 32'd0);
        check("step_busy1_strobes", 32'(strobes()), 32'b1111000);
        next_cycle();
        sample();
        check("step_busy2_halted", 32'(halted_o), 32'd0);
        next_cycle();
        dmem_busy_i = 0; halt_req_i = 1;
        sample();
        check("step_free_halted", 32'(halted_o), 32'd0);
        check("step_free_strobes", 32'(strobes()), 32'b0000001);
        next_cycle();
        halt_req_i = 0;
        sample();
        check("step_rehalted", 32'(halted_o), 32'd1);
        check("step_rehalt_strobes", 32'(strobes()), 32'b1111000);
        resume_req_i = 1; step_req_i = 1;
        next_cycle();
        resume_req_i = 0; step_req_i = 0;
        sample();
        check("resume_halted", 32'(halted_o), 32'd0);
        check("resume_strobes", 32'(strobes()), 32'd0);
        check("debug_stall_cnt", 32'(stall_cnt_o), 32'd0);
        check("debug_err", 32'(err_timeout_o), 32'd0);

        // Timeout: 3 busy, 1 idle, 4 busy; flag is sticky until reset.
        do_reset();
        dmem_busy_i = 1;
        repeat (3) next_cycle();
        dmem_busy_i = 0;
        sample();
        check("to_after3_err", 32'(err_timeout_o), 32'd0);
        next_cycle();
        dmem_busy_i = 1;
        repeat (3) next_cycle();
        sample();
        check("to_run3_err", 32'(err_timeout_o), 32'd0);
        next_cycle();
        sample();
        check("to_run4_err", 32'(err_timeout_o), 32'd1);
        dmem_busy_i = 0;
        repeat (2) next_cycle();
        sample();
        check("to_sticky_err", 32'(err_timeout_o), 32'd1);
        check("to_stall_cnt_sat", 32'(stall_cnt_o), 32'd3);
        do_reset();
        sample();
        check("to_reset_err", 32'(err_timeout_o), 32'd0);
        check("to_reset_stall_cnt", 32'(stall_cnt_o), 32'd0);

        // Counter saturation: held load-use stalls, repeated redirects.
        drive_load_use();
        repeat (2) next_cycle();
        sample();
        check("sat_stall_cnt2", 32'(stall_cnt_o), 32'd2);
        repeat (3) next_cycle();
        sample();
        check("sat_stall_cnt5", 32'(stall_cnt_o), 32'd3);
        do_reset();
        bj_sig_i = 1; ex_valid_i = 1;
        repeat (5) next_cycle();
        sample();
        check("sat_flush_cnt5", 32'(flush_cnt_o), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF → ID → EX → MEM → WB). Generates the per-stage stall/flush strobes consumed by if_stage, id_stage, ex_stage and mem_stage, covering:
- load-use bubbles
- branch/jump redirect flushes
- data-memory wait freezes
- a debug halt/single-step state machine

Keeps saturating performance counters and a sticky dmem-timeout error flag.

Parameters:
CNT_W, 32, width of stall/flush performance counters (saturating)
BUSY_TIMEOUT, 64, consecutive dmem_busy_i cycles after which err_timeout_o sets (must be ≥1)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous active-high reset
id_rs1_addr_i  in  5  rs1 field of instruction in IF/ID register
id_rs2_addr_i  in  5  rs2 field of instruction in IF/ID register
id_uses_rs1_i  in  1  IF/ID instruction reads rs1
id_uses_rs2_i  in  1  IF/ID instruction reads rs2
id_valid_i  in  1  IF/ID register holds valid instruction
ex_memread_i  in  1  ID/EX instruction is a load
ex_rd_addr_i  in  5  ID/EX destination register
ex_valid_i  in  1  ID/EX register valid
bj_sig_i  in  1  taken branch/jump resolved in EX (combinational from ex_stage)
dmem_busy_i  in  1  data memory not ready; MEM must hold
halt_req_i  in  1  debug halt request (level)
step_req_i  in  1  single-step pulse (honoured only in HALTED)
resume_req_i  in  1  resume pulse (honoured only in HALTED)
stall_if_o / stall_id_o / stall_ex_o / stall_mem_o  out  1 each  hold that stage's output register and PC
flush_if_o / flush_id_o / flush_ex_o  out  1 each  clear valid of that stage's output register at next edge
halted_o  out  1  FSM in HALTED
stall_cnt_o  out  CNT_W  cycles with stall_if_o=1 while in RUN
flush_cnt_o  out  CNT_W  branch/jump redirect flushes taken
err_timeout_o  out  1  sticky: dmem_busy_i held ≥ BUSY_TIMEOUT consecutive cycles

Behaviour:
- Reset (rst_i=1 at edge): FSM=RUN, counters=0, busy counter=0, err_timeout_o=0. All stall/flush outputs are 0 while in RUN with no hazard.
- FSM states: RUN, HALTED, STEP.
- Strobe outputs are combinational from current state and inputs. Counters, FSM and error flag are registered.
- Freeze condition: FRZ = dmem_busy_i | (state==HALTED).
  - FRZ=1 → all four stalls=1, all flushes=0.
  - bj_sig_i and load-use are ignored under FRZ; the EX instruction is held, so the condition re-evaluates after the freeze.
- Redirect (no FRZ, bj_sig_i & ex_valid_i): flush_if_o=1 and flush_id_o=1 for that cycle. No stalls. flush_cnt_o increments. Redirect has priority over load-use, since the ID instruction is on the wrong path.
- Load-use (no FRZ, no redirect):
  - Condition: ex_valid_i & ex_memread_i & id_valid_i & ex_rd_addr_i≠0 & ((id_uses_rs1_i & rs1==rd) | (id_uses_rs2_i & rs2==rd)).
  - Response: stall_if_o=1 and flush_id_o=1 (one bubble into ID/EX).
  - Lasts exactly one cycle: the load moves on next edge, so the condition drops.
- flush_ex_o asserts only in STEP when dmem_busy_i=0 and halt_req_i=1, killing nothing else. It is reserved for debug re-halt (see STEP); otherwise 0.
- FSM transitions (evaluated each edge, reset dominant):
  - RUN: halt_req_i → HALTED; else RUN.
  - HALTED: resume_req_i → RUN; else step_req_i → STEP; else HALTED. resume wins if both.
  - STEP: pipeline advances (no HALTED freeze). If dmem_busy_i=1, stay STEP (the step is not consumed); else → HALTED. Exactly one non-frozen advance per step request.
- halt_req_i asserted mid-load-use or mid-redirect: that cycle's strobes are still issued; the freeze starts next cycle.
- Counters:
  - stall_cnt_o increments when state==RUN and stall_if_o=1 (freezes included).
  - Both counters saturate at all-ones, with no wrap.
- Timeout:
  - The busy counter counts consecutive dmem_busy_i=1 cycles and clears on dmem_busy_i=0.
  - When it reaches BUSY_TIMEOUT, err_timeout_o sets and stays until reset.
  - The busy counter saturates.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, ex_valid=1, id_rs2=5, uses_rs2=1, id_valid=1 → cycle 0: stall_if=1, flush_id=1; cycle 1 (load moved on): all strobes 0; stall_cnt=1.
- rd=x0 guard: same as above but ex_rd=0 → no stall/flush.
- Redirect beats load-use: bj_sig=1, ex_valid=1 together with a load-use match → flush_if=1, flush_id=1, stall_if=0; flush_cnt=1.
- dmem freeze with pending branch: dmem_busy=1 for 3 cycles with bj_sig=1 → 3 cycles of all stalls=1 and flushes=0; then cycle 4 gives flush_if=flush_id=1; stall_cnt=3, flush_cnt=1.
- Halt/step/resume:
  - halt_req pulse → halted_o=1 next cycle, all stalls=1.
  - step_req with dmem_busy=1 for 2 cycles → remains STEP 2 cycles, then one free cycle, then HALTED.
  - resume_req and step_req together → RUN.
- Timeout and saturation: BUSY_TIMEOUT=4. dmem_busy high 3 cycles, low 1, high 4 → err_timeout_o sets only after the 4th consecutive busy cycle and stays 1. Then rst_i → 0. CNT_W=2 with 5 stall cycles → stall_cnt_o=3.
